// File: rtl/rw_seq_pkg.sv
// rw_seq_pkg: shared state/error encodings and sizing helpers for rw_seq_checker
package rw_seq_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_WR, WR, RD} state_e;
  localparam int ERR_W = 3;
  typedef enum logic [ERR_W-1:0] {
    ERR_NONE     = 3'd0,
    ERR_ORDER    = 3'd1,
    ERR_TIMEOUT  = 3'd2,
    ERR_WR_SHORT = 3'd3,
    ERR_RD_SHORT = 3'd4,
    ERR_OVERLAP  = 3'd5,
    ERR_RESTART  = 3'd6
  } err_e;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/rw_seq_chan.sv
// rw_seq_chan: one channel of the start/write/read sequence checker
module rw_seq_chan
  import rw_seq_pkg::*;
#(
  parameter int WR_LEN  = 1,
  parameter int RD_LEN  = 2,
  parameter int WR_WAIT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr,
  input  logic             rd,
  input  logic             cnt_clr,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [ERR_W-1:0] err_code,
  output logic             overlap,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);
  localparam int CW = $clog2(max3(WR_LEN, RD_LEN, WR_WAIT) + 1);
  localparam logic [CW-1:0] WRL = CW'(WR_LEN);
  localparam logic [CW-1:0] RDL = CW'(RD_LEN);
  localparam logic [CW-1:0] WWL = CW'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  state_e state_q, state_d;
  err_e err_q, err_d, e;
  logic [CW-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d;
  logic start_q, start_d, pass_q, pass_d, fail_q, fail_d, ovl_q, ovl_d, rise;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, fcnt_q, fcnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    e       = ERR_NONE;
    start_d = start;
    ovl_d   = rd & wr;
    rise    = start & ~start_q;
    case (state_q)
      WAIT_WR:
        if (rd) e = ERR_ORDER;
        else if (wr) begin
          state_d = (WR_LEN == 1) ? RD : WR;
          cnt_d   = (WR_LEN == 1) ? '0 : CW'(1);
        end
        else if (wcnt_q == WWL) e = ERR_TIMEOUT;
        else wcnt_d = wcnt_q + 1'b1;
      WR:
        if (!wr) e = ERR_WR_SHORT;
        else if (cnt_q + 1'b1 == WRL) begin
          state_d = RD;
          cnt_d   = '0;
        end
        else cnt_d = cnt_q + 1'b1;
      RD:
        if (!rd || wr) e = ERR_RD_SHORT;
        else if (cnt_q + 1'b1 == RDL) begin
          pass_d  = 1'b1;
          state_d = IDLE;
        end
        else cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
    // overlap outranks every other error; restart only applies when nothing else happened
    if (ovl_d && state_q != IDLE) e = ERR_OVERLAP;
    if (rise && state_q != IDLE && !pass_d && e == ERR_NONE) e = ERR_RESTART;
    if (e != ERR_NONE) begin
      fail_d  = 1'b1;
      pass_d  = 1'b0;
      err_d   = e;
      state_d = IDLE;
    end
    if (rise) begin
      state_d = WAIT_WR;
      wcnt_d  = '0;
    end
    pcnt_d = cnt_clr ? '0 : (pass_d && pcnt_q != CMAX) ? pcnt_q + 1'b1 : pcnt_q;
    fcnt_d = cnt_clr ? '0 : (fail_d && fcnt_q != CMAX) ? fcnt_q + 1'b1 : fcnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      start_q <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      ovl_q   <= 1'b0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      start_q <= start_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ovl_q   <= ovl_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign err_code = err_q;
  assign overlap  = ovl_q;
  assign pass_cnt = pcnt_q;
  assign fail_cnt = fcnt_q;
endmodule

// File: rtl/rw_seq_checker.sv
// rw_seq_checker: NCH independent start/write/read sequence checkers with packed status outputs
module rw_seq_checker
  import rw_seq_pkg::*;
#(
  parameter int NCH     = 1,
  parameter int WR_LEN  = 1,
  parameter int RD_LEN  = 2,
  parameter int WR_WAIT = 1,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         start,
  input  logic [NCH-1:0]         wr,
  input  logic [NCH-1:0]         rd,
  input  logic                   cnt_clr,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         pass,
  output logic [NCH-1:0]         fail,
  output logic [NCH*ERR_W-1:0]   err_code,
  output logic [NCH-1:0]         overlap,
  output logic [NCH*CNT_W-1:0]   pass_cnt,
  output logic [NCH*CNT_W-1:0]   fail_cnt
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    rw_seq_chan #(
      .WR_LEN(WR_LEN), .RD_LEN(RD_LEN), .WR_WAIT(WR_WAIT), .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .start    (start[i]),
      .wr       (wr[i]),
      .rd       (rd[i]),
      .cnt_clr  (cnt_clr),
      .busy     (busy[i]),
      .pass     (pass[i]),
      .fail     (fail[i]),
      .err_code (err_code[i*ERR_W +: ERR_W]),
      .overlap  (overlap[i]),
      .pass_cnt (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt (fail_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_rw_seq_checker.sv
// tb_rw_seq_checker: directed checks of the rw_seq_checker sequence rules and counters
module tb_rw_seq_checker;
  logic clk = 1'b0, rst = 1'b1, cnt_clr = 1'b0;
  logic [1:0] start = '0, wr = '0, rd = '0;
  logic [1:0] busy, pass, fail, overlap;
  logic [5:0] err_code;
  logic [15:0] pass_cnt, fail_cnt;
  logic start_b = 1'b0, wr_b = 1'b0, rd_b = 1'b0, clr_b = 1'b0;
  logic busy_b, pass_b, fail_b, ovl_b;
  logic [2:0] err_b;
  logic [1:0] pcnt_b, fcnt_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  rw_seq_checker #(.NCH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .wr(wr), .rd(rd), .cnt_clr(cnt_clr),
    .busy(busy), .pass(pass), .fail(fail), .err_code(err_code), .overlap(overlap),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  rw_seq_checker #(.NCH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .wr(wr_b), .rd(rd_b), .cnt_clr(clr_b),
    .busy(busy_b), .pass(pass_b), .fail(fail_b), .err_code(err_b), .overlap(ovl_b),
    .pass_cnt(pcnt_b), .fail_cnt(fcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = '0; wr = '0; rd = '0; cnt_clr = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_ch1(input string tag);
    chk(tag, {busy[1], pass[1], fail[1], overlap[1], err_code[5:3], pass_cnt[15:8], fail_cnt[15:8]}, 0);
  endtask

  task automatic pass_b_seq(input logic clr);
    start_b = 1'b1; cyc();
    start_b = 1'b0; wr_b = 1'b1; cyc();
    wr_b = 1'b0; rd_b = 1'b1; cyc();
    clr_b = clr; cyc();
    chk("b_pass_pulse", pass_b, 1);
    rd_b = 1'b0; clr_b = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("reset_a", {busy, pass, fail, overlap, err_code, pass_cnt, fail_cnt}, 0);
    chk("reset_b", {busy_b, pass_b, fail_b, ovl_b, err_b, pcnt_b, fcnt_b}, 0);

    // 1: golden sequence
    cyc();
    start[0] = 1'b1; cyc();
    chk("t1_busy_c2", busy[0], 1);
    start[0] = 1'b0; wr[0] = 1'b1; cyc();
    chk("t1_busy_c3", busy[0], 1);
    wr[0] = 1'b0; rd[0] = 1'b1; cyc();
    chk("t1_c4", {busy[0], pass[0]}, 2'b10);
    cyc();
    chk("t1_pass_c5", {busy[0], pass[0], fail[0]}, 3'b010);
    chk("t1_pass_cnt", pass_cnt[7:0], 1);
    rd[0] = 1'b0; cyc();
    chk("t1_pass_drop", pass[0], 0);
    chk_ch1("t1_ch1_idle");

    // 2: overlap in WAIT_WR
    do_reset(); cyc();
    start[0] = 1'b1; cyc();
    start[0] = 1'b0; rd[0] = 1'b1; wr[0] = 1'b1; cyc();
    chk("t2_ovl_fail", {overlap[0], fail[0], pass[0]}, 3'b110);
    chk("t2_err", err_code[2:0], 5);
    rd[0] = 1'b0; wr[0] = 1'b0; cyc();
    chk("t2_after", {overlap[0], fail[0], busy[0], err_code[2:0], fail_cnt[7:0]}, {3'b000, 3'd5, 8'd1});
    chk_ch1("t2_ch1_idle");

    // 3: wr too late
    do_reset(); cyc();
    start[0] = 1'b1; cyc();
    start[0] = 1'b0; cyc();
    chk("t3_timeout", {fail[0], err_code[2:0]}, {1'b1, 3'd2});
    wr[0] = 1'b1; cyc();
    chk("t3_late_wr", {fail[0], busy[0], pass[0]}, 0);
    wr[0] = 1'b0;
    chk_ch1("t3_ch1_idle");

    // 4: rd too short
    do_reset(); cyc();
    start[0] = 1'b1; cyc();
    start[0] = 1'b0; wr[0] = 1'b1; cyc();
    wr[0] = 1'b0; rd[0] = 1'b1; cyc();
    rd[0] = 1'b0; cyc();
    chk("t4_rd_short", {fail[0], pass[0], err_code[2:0]}, {2'b10, 3'd4});
    chk_ch1("t4_ch1_idle");

    // 5: restart mid-RD then clean sequence
    do_reset(); cyc();
    start[0] = 1'b1; cyc();
    start[0] = 1'b0; wr[0] = 1'b1; cyc();
    start[0] = 1'b1; wr[0] = 1'b0; rd[0] = 1'b1; cyc();
    chk("t5_restart", {fail[0], busy[0], err_code[2:0]}, {2'b11, 3'd6});
    wr[0] = 1'b1; rd[0] = 1'b0; cyc();
    chk("t5_c5", {fail[0], busy[0]}, 2'b01);
    wr[0] = 1'b0; rd[0] = 1'b1; cyc();
    chk("t5_c6", {pass[0], busy[0]}, 2'b01);
    cyc();
    chk("t5_pass_c7", {pass[0], fail[0], busy[0]}, 3'b100);
    chk("t5_cnts", {pass_cnt[7:0], fail_cnt[7:0]}, {8'd1, 8'd1});
    start[0] = 1'b0; rd[0] = 1'b0;
    chk_ch1("t5_ch1_idle");

    // 6: async reset mid-RD
    do_reset(); cyc();
    start[0] = 1'b1; cyc();
    start[0] = 1'b0; wr[0] = 1'b1; cyc();
    wr[0] = 1'b0; rd[0] = 1'b1; cyc();
    #2 rst = 1'b1;
    #1 chk("t6_rst_now", {busy, pass, fail, overlap, err_code, pass_cnt, fail_cnt}, 0);
    cyc();
    chk("t6_no_pass", {pass[0], busy[0]}, 0);
    rst = 1'b0; rd[0] = 1'b0;

    // saturating counter and clear on dut_b
    for (int k = 0; k < 5; k++) pass_b_seq(1'b0);
    chk("b_sat", pcnt_b, 3);
    pass_b_seq(1'b1);
    chk("b_clr_wins", pcnt_b, 0);
    cyc();
    chk("b_after_clr", {pcnt_b, fcnt_b}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
